// File: rtl/bwn_pkg.sv
// Shared types and sizing helpers for the BWN serial datapath.
package bwn_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} shift_unload_state_t;

  // Beats needed to move a bl-bit word ol bits at a time (rounded up).
  function automatic int f_nbeat(input int bl, input int ol);
    return (bl + ol - 1) / ol;
  endfunction

  // Width of a counter that counts 0..n-1, never below one bit.
  function automatic int f_cntw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_unload_cnt.sv
// Beat counter: clear has priority over increment; oTC flags the final count N-1.
module shift_unload_cnt #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         iCLR,
  input  logic         iEN,
  output logic [W-1:0] oCNT,
  output logic         oTC
);

  // Count register: clear wins, otherwise step on enable.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)   oCNT <= '0;
    else if (iCLR) oCNT <= '0;
    else if (iEN)  oCNT <= oCNT + 1'b1;
  end

  assign oTC = (oCNT == W'(N - 1));

endmodule

// File: rtl/shift_unload.sv
// Parallel-in / serial-out unloader: emits a BL-bit word OL bits per beat, LSB chunk first.
// Optional feature: define SHIFT_UNLOAD_DONE_EN to add the oDONE end-of-word pulse.
module shift_unload
  import bwn_pkg::*;
#(
  parameter int OL = 1,
  parameter int BL = 154
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iLOAD,
  input  logic [BL-1:0] iDATA,
  input  logic          iEN,
  input  logic          iABORT,
  output logic          oREADY,
  output logic          oVALID,
  output logic [OL-1:0] oDATA,
  output logic          oLAST,
`ifdef SHIFT_UNLOAD_DONE_EN
  output logic          oDONE,
`endif
  output logic          oBUSY
);

  localparam int NBEAT = f_nbeat(BL, OL);
  localparam int CW    = f_cntw(NBEAT);
  // Register is a whole number of chunks so the final beat pads with zeros.
  localparam int SW    = NBEAT * OL;

  shift_unload_state_t state, stateNxt;
  logic [SW-1:0] sreg;
  logic [CW-1:0] cnt;
  logic          cntTc, xfer, accept, lastXfer;

  assign oBUSY    = (state == SHIFT);
  assign oVALID   = oBUSY;
  assign oLAST    = oBUSY && (cnt == CW'(NBEAT - 1));
  assign oDATA    = oBUSY ? sreg[OL-1:0] : '0;
  assign oREADY   = !iABORT && (!oBUSY || (oLAST && iEN));
  assign accept   = iLOAD && oREADY;
  assign xfer     = oVALID && iEN && !iABORT;
  assign lastXfer = xfer && cntTc;

  shift_unload_cnt #(.N(NBEAT), .W(CW)) u_cnt (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iCLR   (iABORT || accept || lastXfer),
    .iEN    (xfer && !cntTc),
    .oCNT   (cnt),
    .oTC    (cntTc)
  );

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNxt;
  end

  // Next state: abort first, then load (covers back-to-back), then end of word.
  always_comb begin
    stateNxt = state;
    if (iABORT)        stateNxt = IDLE;
    else if (accept)   stateNxt = SHIFT;
    else if (lastXfer) stateNxt = IDLE;
  end

  // Shift register: load, shift zeros in from the top, or clear when the word ends.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                sreg <= '0;
    else if (iABORT)            sreg <= '0;
    else if (accept)            sreg <= SW'(iDATA);
    else if (lastXfer)          sreg <= '0;
    else if (xfer)              sreg <= sreg >> OL;
  end

`ifdef SHIFT_UNLOAD_DONE_EN
  // One-cycle pulse after each last-beat transfer; an abort cancels it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) oDONE <= 1'b0;
    else         oDONE <= lastXfer;
  end
`endif

endmodule

// File: tb/tb_shift_unload.sv
// Directed bench for shift_unload: BL=8/OL=2 vector table, BL=7/OL=2 padding, default-size round trip.
module tb_shift_unload;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // DUT A: BL=8, OL=2
  logic       aLd = 0, aEn = 0, aAb = 0;
  logic [7:0] aD = '0;
  logic       aRdy, aV, aL, aB;
  logic [1:0] aQ;
  // DUT B: BL=7, OL=2
  logic       bLd = 0, bEn = 0, bAb = 0;
  logic [6:0] bD = '0;
  logic       bRdy, bV, bL, bB;
  logic [1:0] bQ;
  // DUT C: defaults
  logic         cLd = 0, cEn = 0, cAb = 0;
  logic [153:0] cD = '0;
  logic         cRdy, cV, cL, cB;
  logic [0:0]   cQ;
`ifdef SHIFT_UNLOAD_DONE_EN
  logic aDn, bDn, cDn;
`endif

  shift_unload #(.OL(2), .BL(8)) u_a (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD(aLd), .iDATA(aD), .iEN(aEn), .iABORT(aAb),
    .oREADY(aRdy), .oVALID(aV), .oDATA(aQ), .oLAST(aL),
`ifdef SHIFT_UNLOAD_DONE_EN
    .oDONE(aDn),
`endif
    .oBUSY(aB));

  shift_unload #(.OL(2), .BL(7)) u_b (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD(bLd), .iDATA(bD), .iEN(bEn), .iABORT(bAb),
    .oREADY(bRdy), .oVALID(bV), .oDATA(bQ), .oLAST(bL),
`ifdef SHIFT_UNLOAD_DONE_EN
    .oDONE(bDn),
`endif
    .oBUSY(bB));

  shift_unload u_c (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD(cLd), .iDATA(cD), .iEN(cEn), .iABORT(cAb),
    .oREADY(cRdy), .oVALID(cV), .oDATA(cQ), .oLAST(cL),
`ifdef SHIFT_UNLOAD_DONE_EN
    .oDONE(cDn),
`endif
    .oBUSY(cB));

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       en;
    logic       ab;
    logic       v;
    logic [1:0] q;
    logic       l;
    logic       r;
    logic       dn;
  } vec_t;

  localparam int NV = 33;
  vec_t tv [NV];

  function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic en, input logic ab,
                              input logic v, input logic [1:0] q, input logic l, input logic r,
                              input logic dn);
    vec_t t;
    t.ld = ld; t.d = d; t.en = en; t.ab = ab;
    t.v = v; t.q = q; t.l = l; t.r = r; t.dn = dn;
    return t;
  endfunction

  logic [153:0] word, rx;
  int           beats;
  logic [1:0]   padExp [4];

  initial begin
    // Basic word 8'hB4 -> 00,01,11,10
    tv[0]  = mk(1, 8'hB4, 1, 0, 0, 2'b00, 0, 1, 0);
    tv[1]  = mk(0, 8'h00, 1, 0, 1, 2'b00, 0, 0, 0);
    tv[2]  = mk(0, 8'h00, 1, 0, 1, 2'b01, 0, 0, 0);
    tv[3]  = mk(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0);
    tv[4]  = mk(0, 8'h00, 1, 0, 1, 2'b10, 1, 1, 0);
    tv[5]  = mk(0, 8'h00, 1, 0, 0, 2'b00, 0, 1, 1);
    // Stall for 3 cycles on beat 1
    tv[6]  = mk(1, 8'hB4, 1, 0, 0, 2'b00, 0, 1, 0);
    tv[7]  = mk(0, 8'h00, 1, 0, 1, 2'b00, 0, 0, 0);
    tv[8]  = mk(0, 8'h00, 0, 0, 1, 2'b01, 0, 0, 0);
    tv[9]  = mk(0, 8'h00, 0, 0, 1, 2'b01, 0, 0, 0);
    tv[10] = mk(0, 8'h00, 0, 0, 1, 2'b01, 0, 0, 0);
    tv[11] = mk(0, 8'h00, 1, 0, 1, 2'b01, 0, 0, 0);
    tv[12] = mk(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0);
    tv[13] = mk(0, 8'h00, 1, 0, 1, 2'b10, 1, 1, 0);
    tv[14] = mk(0, 8'h00, 1, 0, 0, 2'b00, 0, 1, 1);
    // Back-to-back B4 then 1E, mid-word load ignored, stall on last beat
    tv[15] = mk(1, 8'hB4, 1, 0, 0, 2'b00, 0, 1, 0);
    tv[16] = mk(1, 8'h1E, 1, 0, 1, 2'b00, 0, 0, 0);
    tv[17] = mk(0, 8'h00, 1, 0, 1, 2'b01, 0, 0, 0);
    tv[18] = mk(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0);
    tv[19] = mk(1, 8'h1E, 1, 0, 1, 2'b10, 1, 1, 0);
    tv[20] = mk(0, 8'h00, 1, 0, 1, 2'b10, 0, 0, 1);
    tv[21] = mk(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0);
    tv[22] = mk(0, 8'h00, 1, 0, 1, 2'b01, 0, 0, 0);
    tv[23] = mk(0, 8'h00, 0, 0, 1, 2'b00, 1, 0, 0);
    tv[24] = mk(0, 8'h00, 1, 0, 1, 2'b00, 1, 1, 0);
    tv[25] = mk(0, 8'h00, 1, 0, 0, 2'b00, 0, 1, 1);
    // Abort with a load during beat 2
    tv[26] = mk(1, 8'hB4, 1, 0, 0, 2'b00, 0, 1, 0);
    tv[27] = mk(0, 8'h00, 1, 0, 1, 2'b00, 0, 0, 0);
    tv[28] = mk(0, 8'h00, 1, 0, 1, 2'b01, 0, 0, 0);
    tv[29] = mk(1, 8'h1E, 1, 1, 1, 2'b11, 0, 0, 0);
    tv[30] = mk(0, 8'h00, 1, 0, 0, 2'b00, 0, 1, 0);
    // Abort with a load from IDLE: load dropped
    tv[31] = mk(1, 8'hB4, 1, 1, 0, 2'b00, 0, 0, 0);
    tv[32] = mk(0, 8'h00, 1, 0, 0, 2'b00, 0, 1, 0);

    // Reset state
    #2;
    chk("rst valid", aV, 0);
    chk("rst busy",  aB, 0);
    chk("rst last",  aL, 0);
    chk("rst data",  aQ, 0);
    chk("rst ready", aRdy, 1);
`ifdef SHIFT_UNLOAD_DONE_EN
    chk("rst done",  aDn, 0);
`endif
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Table
    for (int i = 0; i < NV; i++) begin
      @(negedge iCLK);
      aLd = tv[i].ld; aD = tv[i].d; aEn = tv[i].en; aAb = tv[i].ab;
      #1;
      chk($sformatf("v%0d valid", i), aV, tv[i].v);
      chk($sformatf("v%0d data", i),  aQ, tv[i].q);
      chk($sformatf("v%0d last", i),  aL, tv[i].l);
      chk($sformatf("v%0d ready", i), aRdy, tv[i].r);
      chk($sformatf("v%0d busy", i),  aB, tv[i].v);
`ifdef SHIFT_UNLOAD_DONE_EN
      chk($sformatf("v%0d done", i),  aDn, tv[i].dn);
`endif
      if (i == 9) chk("stall cnt", u_a.cnt, 1);
    end

    // Reset asserted mid-word
    @(negedge iCLK);
    aLd = 1; aD = 8'h1E; aEn = 1; aAb = 0;
    @(negedge iCLK);
    aLd = 0;
    @(negedge iCLK);
    #1;
    chk("pre-rst data", aQ, 2'b11);
    iRST_N = 1'b0;
    #1;
    chk("midrst valid", aV, 0);
    chk("midrst data",  aQ, 0);
    chk("midrst last",  aL, 0);
    chk("midrst busy",  aB, 0);
    chk("midrst ready", aRdy, 1);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    chk("postrst ready", aRdy, 1);
    chk("postrst valid", aV, 0);
    @(negedge iCLK);
    #1;
    chk("postrst idle", aV, 0);

    // Padding: BL=7, OL=2, 7'h55 -> 01,01,01,01
    padExp[0] = 2'b01; padExp[1] = 2'b01; padExp[2] = 2'b01; padExp[3] = 2'b01;
    @(negedge iCLK);
    bLd = 1; bD = 7'h55; bEn = 1;
    @(negedge iCLK);
    bLd = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("pad%0d valid", k), bV, 1);
      chk($sformatf("pad%0d data", k),  bQ, padExp[k]);
      chk($sformatf("pad%0d last", k),  bL, (k == 3) ? 1'b1 : 1'b0);
      @(negedge iCLK);
    end
    #1;
    chk("pad idle", bV, 0);

    // Default size: random word rebuilt by an MSB-in receiver
    word = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rx = '0;
    beats = 0;
    @(negedge iCLK);
    cLd = 1; cD = word; cEn = 1;
    @(negedge iCLK);
    cLd = 0;
    for (int n = 0; n < 2000 && beats < 154; n++) begin
      cEn = ($urandom_range(0, 3) != 0);
      #1;
      if (cV && cEn) begin
        rx = {cQ, rx[153:1]};
        beats++;
        if (beats == 154) chk("rt last flag", cL, 1);
      end
      @(negedge iCLK);
    end
    chk("rt beats", beats, 154);
    chk("rt word", rx, word);
    cEn = 1;
    #1;
    chk("rt idle", cV, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/shift_unload.md
# shift_unload

Parallel-in/serial-out unloader for the BWN datapath. It is the transmit-side counterpart of the serial-in buffer register. It accepts a BL-bit word on a load handshake and emits it OL bits per beat, LSB chunk first, under a valid/enable handshake. A receiver that shifts each incoming chunk in at the MSB rebuilds the original word bit-exactly after NBEAT beats.

## Interface
- `OL`, default 1: output chunk width in bits.
- `BL`, default 154: parallel word width in bits.
- `NBEAT`, derived as ceil(BL/OL): beats per word; not overridable.

- `iCLK`, input, 1: single clock, rising-edge.
- `iRST_N`, input, 1: reset, asynchronous, active-low.
- `iLOAD`, input, 1: load request; the word is accepted when `iLOAD && oREADY`.
- `iDATA`, input, BL: parallel word, sampled on accept.
- `iEN`, input, 1: downstream advance; a beat transfers when `oVALID && iEN`.
- `iABORT`, input, 1: synchronous clear to IDLE; highest priority after reset.
- `oREADY`, output, 1: block can accept a load this cycle.
- `oVALID`, output, 1: `oDATA` holds a valid beat.
- `oDATA`, output, OL: current chunk.
- `oLAST`, output, 1: current beat is beat NBEAT-1.
- `oBUSY`, output, 1: state is SHIFT.

## Operation
- States:
  - IDLE: `oVALID` = 0.
  - SHIFT: `oVALID` = 1. Holds the shift register `sreg[BL-1:0]` and the beat counter `cnt`. `cnt` is clog2(NBEAT) bits wide, minimum 1.
- Accepting a load: `sreg` ← `iDATA`, `cnt` ← 0, state → SHIFT.
- `oDATA` = `sreg[OL-1:0]`. On a transfer that is not the last beat: `sreg` ← `{OL'b0, sreg[BL-1:OL]}`, `cnt` ← `cnt`+1.
- Padding: if BL mod OL ≠ 0, the missing upper bits of the final beat are driven 0.
- `oLAST` = SHIFT && `cnt` == NBEAT-1.
- Transfer of the last beat: state → IDLE, unless a load is accepted in the same cycle. In that case the new word is loaded and the state stays SHIFT (back-to-back, no bubble).
- `oREADY` = IDLE || (`oLAST` && `iEN`). It is combinational from state and `iEN`.
- A load while busy and not on the last transfer is not accepted (`oREADY` = 0). The request is ignored, not queued.
- `iABORT` = 1: state → IDLE, `sreg` ← 0, `cnt` ← 0. A simultaneous `iLOAD` is dropped, and `oREADY` is forced to 0 that cycle.
- `iEN` low in SHIFT: `sreg`, `cnt` and `oDATA` hold indefinitely.

## Timing
- Reset values: state IDLE, `sreg` = 0, `cnt` = 0, `oVALID` = `oBUSY` = `oLAST` = 0, `oDATA` = 0, `oREADY` = 1.
- Reset asserted mid-word: immediate abort of the word with no partial output afterwards. After release the block is in IDLE.
- Load accepted at edge k: `oVALID` = 1 and `oDATA` = `iDATA[OL-1:0]` from edge k.
- With `iEN` held high, beat i is presented during cycle k+i, and `oLAST` is presented during cycle k+NBEAT-1.
- With `iEN` high, a back-to-back load yields exactly NBEAT cycles per word and continuous `oVALID`.
- All registered outputs change only on `iCLK` rising edges or on reset assertion.

## Configuration
- `SHIFT_UNLOAD_DONE_EN` defined: adds output `oDONE` (1 bit, reset 0). It is a one-cycle pulse on the edge after the last-beat transfer, and also fires on back-to-back words. `iABORT` suppresses a pending pulse.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `bwn_pkg`:
  - state enum `shift_unload_state_t` {IDLE, SHIFT};
  - function `f_nbeat(BL, OL)`;
  - counter-width function `f_cntw(n)` = max(1, clog2(n)).
- One sub-module, `shift_unload_cnt`: the beat counter with clear, enable and terminal-count flag. It is reusable by the matching receiver controller.
- Everything else stays in `shift_unload`.

## Test plan
- Basic word, BL=8, OL=2: load 8'hB4 with `iEN`=1. Required: beats 2'b00, 2'b01, 2'b11, 2'b10 in 4 consecutive cycles; `oLAST` only on the 4th beat; back to IDLE with `oVALID`=0 on the following cycle.
- Stall: same word, `iEN` low for 3 cycles after beat 1. Required: `oDATA` held at 2'b01, `cnt` unchanged, then beats 2'b11, 2'b10 resume.
- Back-to-back: load 8'hB4, then load 8'h1E during the last-beat transfer. Required: 8 continuous valid beats 00,01,11,10,10,11,01,00; `oREADY` high only in that overlap cycle; a load attempted mid-word is ignored. With `SHIFT_UNLOAD_DONE_EN`: 2 `oDONE` pulses.
- Padding, BL=7, OL=2: load 7'h55. Required: beats 01, 01, 01, 01, the last being bit 6 plus 0-padding; `oLAST` on the 4th beat.
- Abort and reset:
  - `iABORT` together with `iLOAD` during beat 2: IDLE next cycle, no new word, no `oDONE`.
  - `iRST_N` low mid-word: all outputs at reset values immediately, `oREADY`=1 after release.
- Default parameters, OL=1, BL=154: a random word loaded into this block, fed into the receiver buffer with its enable driven from `oVALID && iEN`, reproduces the word after 154 beats.
